// File: rtl/trdb_pkg.sv
// Shared types for the trace-debug sample buffer: payload record, capture mode and
// buffer state. Payload field widths are fixed here and used as the module defaults.
package trdb_pkg;

    localparam int unsigned TRDB_XLEN     = 32;
    localparam int unsigned TRDB_CAUSELEN = 5;
    localparam int unsigned TRDB_PRIVLEN  = 3;

    typedef enum logic {
        MODE_ALL = 1'b0,
        MODE_EXC = 1'b1
    } trdb_mode_e;

    typedef enum logic [1:0] {
        BUF_IDLE,
        BUF_ARMED,
        BUF_POST,
        BUF_DONE
    } trdb_buf_state_e;

    typedef struct packed {
        logic                     exception;
        logic                     interrupt;
        logic [TRDB_CAUSELEN-1:0] cause;
        logic [TRDB_XLEN-1:0]     tval;
        logic [TRDB_PRIVLEN-1:0]  priv;
        logic [TRDB_XLEN-1:0]     iaddr;
        logic [TRDB_XLEN-1:0]     instr;
        logic                     compressed;
    } sample_t;

    function automatic logic sample_wanted(trdb_mode_e mode, logic exc, logic irq);
        return (mode == MODE_ALL) || exc || irq;
    endfunction

endpackage

// File: rtl/trdb_sample_fifo.sv
// Circular sample store with flush and an optional overwrite-oldest policy when full.
// The storage array has no reset; only pointers and occupancy are cleared.
module trdb_sample_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter type         data_t = logic [7:0]
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     overwrite,
    input  data_t                    wr_data,
    output data_t                    rd_data,
    output logic                     full,
    output logic                     empty,
    output logic                     drop,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    data_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_pop;
    logic          blocked;
    logic          evict;
    logic          do_write;

    always_comb begin
        empty    = (count == '0);
        full     = (count == FULL_LEVEL);
        level    = count;
        rd_data  = mem[rd_ptr];
        do_pop   = pop && !empty && !flush;
        // A push into a full buffer is only blocked when no pop frees a slot this edge.
        blocked  = push && full && !do_pop && !flush;
        evict    = blocked && overwrite;
        do_write = push && !flush && (!blocked || overwrite);
        drop     = blocked;
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop || evict) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_write && !do_pop && !evict) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_write) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/trdb_sample_buffer.sv
// Retired-instruction sample capture buffer with address trigger, post-trigger window,
// drop accounting and a valid/ready readout port.
module trdb_sample_buffer
    import trdb_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned XLEN     = TRDB_XLEN,
    parameter int unsigned CAUSELEN = TRDB_CAUSELEN,
    parameter int unsigned PRIVLEN  = TRDB_PRIVLEN
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     ivalid_i,
    input  logic                     iexception_i,
    input  logic                     interrupt_i,
    input  logic                     compressed_i,
    input  logic [CAUSELEN-1:0]      cause_i,
    input  logic [XLEN-1:0]          tval_i,
    input  logic [XLEN-1:0]          iaddr_i,
    input  logic [XLEN-1:0]          instr_i,
    input  logic [PRIVLEN-1:0]       priv_i,
    input  logic                     enable_i,
    input  logic                     mode_i,
    input  logic                     wrap_i,
    input  logic                     trig_en_i,
    input  logic [XLEN-1:0]          trig_addr_i,
    input  logic [7:0]               post_cnt_i,
    input  logic                     clr_i,
    output logic                     sample_valid_o,
    input  logic                     sample_ready_i,
    output sample_t                  sample_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [15:0]              drop_cnt_o,
    output logic                     done_o
);

    trdb_buf_state_e state;
    trdb_buf_state_e state_next;
    logic [7:0]      post_cnt;
    logic            capturing;
    logic            qualify;
    logic            trig_hit;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_drop;
    sample_t         sample_in;

    always_comb begin
        sample_in = '{exception:  iexception_i,
                      interrupt:  interrupt_i,
                      cause:      cause_i,
                      tval:       tval_i,
                      priv:       priv_i,
                      iaddr:      iaddr_i,
                      instr:      instr_i,
                      compressed: compressed_i};
        trig_hit  = trig_en_i && ivalid_i && (iaddr_i == trig_addr_i);
        qualify   = ivalid_i && capturing &&
                    sample_wanted(trdb_mode_e'(mode_i), iexception_i, interrupt_i);
        pop       = sample_valid_o && sample_ready_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            state <= BUF_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!enable_i) begin
            state_next = BUF_IDLE;
        end else begin
            unique case (state)
                BUF_IDLE:  state_next = BUF_ARMED;
                BUF_ARMED: begin
                    if (trig_hit) begin
                        state_next = (post_cnt_i == '0) ? BUF_DONE : BUF_POST;
                    end
                end
                // The last post-trigger sample is captured on the same edge that leaves POST.
                BUF_POST: begin
                    if (qualify && post_cnt == 8'd1) begin
                        state_next = BUF_DONE;
                    end
                end
                BUF_DONE:  state_next = BUF_DONE;
                default:   state_next = BUF_IDLE;
            endcase
        end
    end

    always_comb begin
        capturing = (state == BUF_ARMED) || (state == BUF_POST);
        done_o    = (state == BUF_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            post_cnt <= '0;
        end else if (state == BUF_ARMED && trig_hit) begin
            post_cnt <= post_cnt_i;
        end else if (state == BUF_POST && qualify && post_cnt != '0) begin
            post_cnt <= post_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            drop_cnt_o <= '0;
        end else if (fifo_drop && drop_cnt_o != '1) begin
            drop_cnt_o <= drop_cnt_o + 16'd1;
        end
    end

    trdb_sample_fifo #(
        .DEPTH  (DEPTH),
        .data_t (sample_t)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .flush     (clr_i),
        .push      (qualify),
        .pop       (pop),
        .overwrite (wrap_i),
        .wr_data   (sample_in),
        .rd_data   (sample_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (fifo_drop),
        .level     (level_o)
    );

    always_comb begin
        sample_valid_o = !fifo_empty;
    end

endmodule

// File: tb/tb_trdb_sample_buffer.sv
// Scoreboard bench: a queue-based buffer model predicts readout and occupancy;
// a negedge monitor compares every handshaked sample against the expected queue.
module tb_trdb_sample_buffer;
    import trdb_pkg::*;

    localparam int DEPTH = 16;

    logic                     clk;
    logic                     rst_i;
    logic                     ivalid_i;
    logic                     iexception_i;
    logic                     interrupt_i;
    logic                     compressed_i;
    logic [TRDB_CAUSELEN-1:0] cause_i;
    logic [TRDB_XLEN-1:0]     tval_i;
    logic [TRDB_XLEN-1:0]     iaddr_i;
    logic [TRDB_XLEN-1:0]     instr_i;
    logic [TRDB_PRIVLEN-1:0]  priv_i;
    logic                     enable_i;
    logic                     mode_i;
    logic                     wrap_i;
    logic                     trig_en_i;
    logic [TRDB_XLEN-1:0]     trig_addr_i;
    logic [7:0]               post_cnt_i;
    logic                     clr_i;
    logic                     sample_valid_o;
    logic                     sample_ready_i;
    sample_t                  sample_o;
    logic [$clog2(DEPTH):0]   level_o;
    logic [15:0]              drop_cnt_o;
    logic                     done_o;

    trdb_sample_buffer #(
        .DEPTH    (DEPTH),
        .XLEN     (TRDB_XLEN),
        .CAUSELEN (TRDB_CAUSELEN),
        .PRIVLEN  (TRDB_PRIVLEN)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .ivalid_i       (ivalid_i),
        .iexception_i   (iexception_i),
        .interrupt_i    (interrupt_i),
        .compressed_i   (compressed_i),
        .cause_i        (cause_i),
        .tval_i         (tval_i),
        .iaddr_i        (iaddr_i),
        .instr_i        (instr_i),
        .priv_i         (priv_i),
        .enable_i       (enable_i),
        .mode_i         (mode_i),
        .wrap_i         (wrap_i),
        .trig_en_i      (trig_en_i),
        .trig_addr_i    (trig_addr_i),
        .post_cnt_i     (post_cnt_i),
        .clr_i          (clr_i),
        .sample_valid_o (sample_valid_o),
        .sample_ready_i (sample_ready_i),
        .sample_o       (sample_o),
        .level_o        (level_o),
        .drop_cnt_o     (drop_cnt_o),
        .done_o         (done_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef enum {M_IDLE, M_ARMED, M_POST, M_DONE} mstate_e;

    int      n_cmp = 0;
    int      n_bad = 0;
    sample_t mq[$];
    sample_t exp_q[$];
    int      mdrop = 0;
    int      mcnt = 0;
    mstate_e mst = M_IDLE;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of one clock edge, using the inputs held across it.
    task automatic apply_edge();
        sample_t cur;
        bit      qual;
        bit      full;
        bit      pop;
        bit      hit;
        if (rst_i || clr_i) begin
            mq.delete();
            mdrop = 0;
            mcnt  = 0;
            mst   = M_IDLE;
            return;
        end
        cur = '{exception: iexception_i, interrupt: interrupt_i, cause: cause_i,
                tval: tval_i, priv: priv_i, iaddr: iaddr_i, instr: instr_i,
                compressed: compressed_i};
        qual = ivalid_i && (mst == M_ARMED || mst == M_POST) &&
               (!mode_i || iexception_i || interrupt_i);
        hit  = trig_en_i && ivalid_i && (iaddr_i == trig_addr_i);
        pop  = sample_ready_i && mq.size() > 0;
        full = (mq.size() == DEPTH);
        if (pop) void'(mq.pop_front());
        if (qual) begin
            if (full && !pop) begin
                if (mdrop != 65535) mdrop++;
                if (wrap_i) begin
                    void'(mq.pop_front());
                    mq.push_back(cur);
                end
            end else begin
                mq.push_back(cur);
            end
        end
        if (!enable_i) begin
            mst = M_IDLE;
        end else begin
            case (mst)
                M_IDLE:  mst = M_ARMED;
                M_ARMED: if (hit) begin
                    mcnt = int'(post_cnt_i);
                    mst  = (mcnt == 0) ? M_DONE : M_POST;
                end
                M_POST:  if (qual) begin
                    mcnt--;
                    if (mcnt == 0) mst = M_DONE;
                end
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        if (!rst_i && !clr_i && sample_ready_i && mq.size() > 0) exp_q.push_back(mq[0]);
        @(posedge clk);
        #1;
        apply_edge();
        check("level", 32'(level_o), 32'(mq.size()));
        check("drop_cnt", 32'(drop_cnt_o), 32'(mdrop));
        check("valid", 32'(sample_valid_o), 32'(mq.size() != 0));
        check("done", 32'(done_o), 32'(mst == M_DONE));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_i && !clr_i && sample_valid_o === 1'b1 && sample_ready_i) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL readout: got %h expected nothing", sample_o);
                end else begin
                    sample_t e;
                    e = exp_q.pop_front();
                    if (sample_o !== e) begin
                        n_bad++;
                        $display("FAIL readout: got %h expected %h", sample_o, e);
                    end
                end
            end
        end
    end

    function automatic sample_t rand_sample();
        sample_t s;
        s.exception  = ($urandom % 5) == 0;
        s.interrupt  = ($urandom % 8) == 0;
        s.cause      = TRDB_CAUSELEN'($urandom);
        s.tval       = $urandom;
        s.priv       = TRDB_PRIVLEN'($urandom);
        s.iaddr      = 32'h1C00_0000 + 32'(4 * ($urandom % 16));
        s.instr      = $urandom;
        s.compressed = 1'($urandom);
        return s;
    endfunction

    function automatic sample_t seq_sample(int i);
        sample_t s;
        s           = rand_sample();
        s.exception = 1'b0;
        s.interrupt = 1'b0;
        s.iaddr     = 32'h1C00_0000 + 32'(4 * i);
        s.tval      = 32'hA000_0000 + 32'(i);
        return s;
    endfunction

    task automatic drive(sample_t s);
        ivalid_i     = 1'b1;
        iexception_i = s.exception;
        interrupt_i  = s.interrupt;
        cause_i      = s.cause;
        tval_i       = s.tval;
        priv_i       = s.priv;
        iaddr_i      = s.iaddr;
        instr_i      = s.instr;
        compressed_i = s.compressed;
    endtask

    task automatic arm();
        ivalid_i  = 1'b0;
        clr_i     = 1'b1;
        enable_i  = 1'b1;
        tick();
        clr_i     = 1'b0;
        tick();
    endtask

    task automatic drain(int n);
        ivalid_i       = 1'b0;
        sample_ready_i = 1'b1;
        repeat (n) tick();
        sample_ready_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; clr_i = 1'b0; enable_i = 1'b0; mode_i = 1'b0; wrap_i = 1'b0;
        trig_en_i = 1'b0; trig_addr_i = '0; post_cnt_i = '0; sample_ready_i = 1'b0;
        drive(seq_sample(0));
        ivalid_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        tick();

        // Overflow with discard-newest, then with overwrite-oldest.
        for (int w = 0; w < 2; w++) begin
            wrap_i = 1'(w);
            arm();
            for (int i = 0; i < 20; i++) begin
                drive(seq_sample(i));
                tick();
            end
            ivalid_i = 1'b0;
            check("full_level", 32'(level_o), 32'd16);
            check("full_drop", 32'(drop_cnt_o), 32'd4);
            check("oldest_tval", sample_o.tval, (w == 0) ? 32'hA000_0000 : 32'hA000_0004);
            drain(18);
        end
        wrap_i = 1'b0;

        // Exception-only mode.
        mode_i = 1'b1;
        arm();
        for (int i = 0; i < 10; i++) begin
            sample_t s;
            s = seq_sample(i);
            s.exception = (i == 3 || i == 7);
            drive(s);
            tick();
        end
        ivalid_i = 1'b0;
        check("exc_level", 32'(level_o), 32'd2);
        drain(4);
        mode_i = 1'b0;

        // Address trigger with three post-trigger samples.
        trig_en_i = 1'b1; trig_addr_i = 32'h1C00_0080; post_cnt_i = 8'd3;
        arm();
        for (int i = 0; i < 12; i++) begin
            sample_t s;
            s = seq_sample(i);
            if (i == 5) s.iaddr = 32'h1C00_0080;
            drive(s);
            tick();
        end
        ivalid_i = 1'b0;
        check("trig_level", 32'(level_o), 32'd9);
        check("trig_done", 32'(done_o), 32'd1);
        drain(12);
        check("done_hold", 32'(done_o), 32'd1);
        enable_i = 1'b0;
        tick();
        enable_i = 1'b1;
        trig_en_i = 1'b0;

        // Full buffer with simultaneous push and pop.
        arm();
        for (int i = 0; i < 16; i++) begin
            drive(seq_sample(i));
            tick();
        end
        sample_ready_i = 1'b1;
        for (int i = 16; i < 24; i++) begin
            drive(seq_sample(i));
            tick();
        end
        check("pp_level", 32'(level_o), 32'd16);
        check("pp_drop", 32'(drop_cnt_o), 32'd0);
        drain(18);

        // Reset in the middle of a post-trigger window.
        arm();
        for (int i = 0; i < 18; i++) begin
            drive(seq_sample(i));
            tick();
        end
        drain(11);
        trig_en_i = 1'b1; trig_addr_i = 32'h1C00_0100; post_cnt_i = 8'd20;
        drive(seq_sample(64));
        tick();
        drive(seq_sample(65));
        tick();
        check("post_level", 32'(level_o), 32'd7);
        check("post_drop", 32'(drop_cnt_o), 32'd2);
        ivalid_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        trig_en_i = 1'b0;
        check("rst_level", 32'(level_o), 32'd0);
        check("rst_valid", 32'(sample_valid_o), 32'd0);
        check("rst_drop", 32'(drop_cnt_o), 32'd0);
        tick();
        drive(seq_sample(70));
        tick();
        check("after_rst_level", 32'(level_o), 32'd1);
        drain(2);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            int seg;
            seg = c / 300;
            rst_i          = ($urandom % 250) == 0;
            clr_i          = ($urandom % 180) == 0;
            enable_i       = ($urandom % 40) != 0;
            mode_i         = (seg % 3) == 1;
            wrap_i         = (seg % 2) == 1;
            trig_en_i      = ($urandom % 3) == 0;
            trig_addr_i    = 32'h1C00_0000 + 32'(4 * ($urandom % 16));
            post_cnt_i     = 8'($urandom % 6);
            sample_ready_i = (seg % 4 == 0) ? (($urandom % 8) == 0) : (($urandom % 3) != 0);
            drive(rand_sample());
            ivalid_i       = ($urandom % 4) != 0;
            tick();
        end
        rst_i = 1'b0;
        clr_i = 1'b0;
        drain(DEPTH + 4);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
